// File: rtl/led_bank_arbiter_if.sv
// Requester-side bus of the LED bank arbiter: requests and patterns in,
// grant, LED drive and status out.
interface led_bank_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] pat;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        led;
  logic              busy;
  logic              preempt;

  // Pattern sources side
  modport master (
    output req,
    output pat,
    input  gnt,
    input  led,
    input  busy,
    input  preempt
  );

  // Arbiter side
  modport slave (
    input  req,
    input  pat,
    output gnt,
    output led,
    output busy,
    output preempt
  );
endinterface

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing a 4-LED bank between NREQ pattern sources.
// A grant lasts at least DWELL_CYCLES, a contended owner is cut off after
// MAX_CYCLES, and an idle bank shows a walking one stepping every STEP_CYCLES.
module led_bank_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned MAX_CYCLES   = 200_000_000,
  parameter int unsigned STEP_CYCLES  = 50_000_000
) (
  input logic               clk,
  input logic               rst,
  led_bank_arbiter_if.slave bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]      state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic [31:0]     cnt_q;
  logic [31:0]     step_q;
  logic [NREQ-1:0] gnt_q;
  // In S_IDLE the LED register doubles as the walk position (0000 = position 0).
  logic [3:0]      led_q;
  logic            busy_q;
  logic            preempt_q;

  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic [3:0]      win_pat;
  logic [3:0]      owner_pat;
  logic            owner_req;
  logic            others_req;
  logic            dwell_done;
  logic            max_hit;
  logic            rel_normal;
  logic            rel_preempt;
  logic [IW-1:0]   ptr_next;
  logic [3:0]      walk_next;

  // Round-robin search: lowest offset from ptr with a set request wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % int'(NREQ);
      if (bus.req[idx]) begin
        win_valid = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  // Ownership decode and release conditions.
  always_comb begin
    win_pat     = bus.pat[32'(win_idx) * 4 +: 4];
    owner_pat   = bus.pat[32'(owner_q) * 4 +: 4];
    owner_req   = bus.req[owner_q];
    others_req  = |(bus.req & ~(NREQ'(1) << owner_q));
    dwell_done  = cnt_q >= DWELL_CYCLES - 32'd1;
    max_hit     = cnt_q >= MAX_CYCLES - 32'd1;
    rel_normal  = dwell_done && !owner_req;
    // Normal release needs owner_req low, so the two can never coincide.
    rel_preempt = max_hit && owner_req && others_req;
    ptr_next    = (32'(owner_q) == NREQ - 32'd1) ? '0 : owner_q + IW'(1);
    walk_next   = (led_q == 4'b0000 || led_q[3]) ? 4'b0001 : {led_q[2:0], 1'b0};
  end

  // Main state machine; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      step_q    <= '0;
      gnt_q     <= '0;
      led_q     <= 4'b0000;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            state_q <= S_OWN;
            owner_q <= win_idx;
            gnt_q   <= NREQ'(1) << win_idx;
            led_q   <= win_pat;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            step_q  <= '0;
          end else if (step_q == STEP_CYCLES - 32'd1) begin
            step_q <= '0;
            led_q  <= walk_next;
          end else begin
            step_q <= step_q + 32'd1;
          end
        end
        S_OWN: begin
          if (rel_normal || rel_preempt) begin
            state_q   <= S_GAP;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            led_q     <= 4'b0000;
            ptr_q     <= ptr_next;
            preempt_q <= rel_preempt;
          end else begin
            led_q <= owner_pat;
            if (!max_hit) begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
          led_q   <= 4'b0000;
          step_q  <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          led_q   <= 4'b0000;
          step_q  <= '0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.led     = led_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: a cycle-level behavioural model is checked
// against the DUT on every falling edge, plus directed literal expectations.
module tb_led_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int DWELL = 4;
  localparam int MAXC  = 10;
  localparam int STEP  = 3;

  logic clk;
  logic rst;

  led_bank_arbiter_if #(.NREQ(NREQ)) bus ();

  led_bank_arbiter #(
    .NREQ         (NREQ),
    .DWELL_CYCLES (DWELL),
    .MAX_CYCLES   (MAXC),
    .STEP_CYCLES  (STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = none), owned-cycle count,
  // one-cycle gap flag and count of idle cycles since the walk restarted.
  int         m_owner = -1;
  int         m_held  = 0;
  bit         m_gap   = 0;
  int         m_idle  = 0;
  int         m_ptr   = 0;
  bit         m_valid = 0;
  logic [3:0] m_led   = 4'b0000;
  bit         m_pre   = 0;

  function automatic logic [3:0] walk(input int n);
    int k;
    k = n / STEP;
    if (k == 0) return 4'b0000;
    return 4'b0001 << ((k - 1) % 4);
  endfunction

  task automatic model_step();
    logic [3:0] p;
    bit nrm;
    bit pre;
    int w;
    m_pre = 0;
    if (rst) begin
      m_owner = -1; m_gap = 0; m_idle = 0; m_ptr = 0; m_led = 4'b0000;
    end else if (m_owner >= 0) begin
      m_held++;
      nrm = (m_held >= DWELL) && !bus.req[m_owner];
      pre = (m_held >= MAXC) && bus.req[m_owner] && ((bus.req & ~(4'b1 << m_owner)) != 0);
      if (nrm || pre) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_gap   = 1;
        m_led   = 4'b0000;
        m_pre   = pre && !nrm;
      end else begin
        p     = bus.pat[m_owner*4 +: 4];
        m_led = p;
      end
    end else if (m_gap) begin
      m_gap = 0; m_idle = 0; m_led = 4'b0000;
    end else if (bus.req != 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      m_owner = w;
      m_held  = 0;
      m_idle  = 0;
      p       = bus.pat[w*4 +: 4];
      m_led   = p;
    end else begin
      m_idle++;
      m_led = walk(m_idle);
    end
    m_valid = 1;
  endtask

  always @(posedge clk) model_step();

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_gnt", 32'(bus.gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("model_led", 32'(bus.led), 32'(m_led));
      chk("model_busy", 32'(bus.busy), 32'(m_owner >= 0));
      chk("model_preempt", 32'(bus.preempt), 32'(m_pre));
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    bus.req = '0;
    bus.pat = 16'h9A53; // pat3=1001 pat2=1010 pat1=0101 pat0=0011
    cyc(2);
    chk("reset_led", 32'(bus.led), 32'h0);
    chk("reset_gnt", 32'(bus.gnt), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_preempt", 32'(bus.preempt), 32'h0);

    // 1: idle walk
    rst = 1'b0;
    cyc(2);
    chk("walk_e2", 32'(bus.led), 32'h0);
    cyc(1);
    chk("walk_e3", 32'(bus.led), 32'h1);
    cyc(3);
    chk("walk_e6", 32'(bus.led), 32'h2);
    cyc(3);
    chk("walk_e9", 32'(bus.led), 32'h4);
    cyc(3);
    chk("walk_e12", 32'(bus.led), 32'h8);
    cyc(3);
    chk("walk_e15_wrap", 32'(bus.led), 32'h1);
    chk("walk_busy", 32'(bus.busy), 32'h0);

    // 2: single pulse on req2, dwell and live pattern tracking
    bus.req = 4'b0100;
    cyc(1);
    chk("t2_gnt", 32'(bus.gnt), 32'h4);
    chk("t2_led", 32'(bus.led), 32'hA);
    chk("t2_busy", 32'(bus.busy), 32'h1);
    bus.req = '0;
    cyc(1);
    bus.pat[11:8] = 4'b0110;
    cyc(1);
    chk("t2_live_pat", 32'(bus.led), 32'h6);
    cyc(1);
    chk("t2_gnt_4th", 32'(bus.gnt), 32'h4);
    cyc(1);
    chk("t2_gap_gnt", 32'(bus.gnt), 32'h0);
    chk("t2_gap_led", 32'(bus.led), 32'h0);
    cyc(3);
    chk("t2_walk_pre", 32'(bus.led), 32'h0);
    cyc(1);
    chk("t2_walk_first", 32'(bus.led), 32'h1);
    bus.pat[11:8] = 4'b1010;

    // 3: req0 and req2 together from reset
    rst = 1'b1;
    cyc(1);
    rst     = 1'b0;
    bus.req = 4'b0101;
    cyc(1);
    chk("t3_gnt0", 32'(bus.gnt), 32'h1);
    chk("t3_led0", 32'(bus.led), 32'h3);
    bus.req = 4'b0100;
    cyc(4);
    chk("t3_release", 32'(bus.gnt), 32'h0);
    cyc(1);
    chk("t3_idle_gnt", 32'(bus.gnt), 32'h0);
    cyc(1);
    chk("t3_gnt2", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    cyc(6);

    // 4: preemption of req1 by req3
    bus.req = 4'b0010;
    cyc(1);
    chk("t4_gnt1", 32'(bus.gnt), 32'h2);
    chk("t4_led1", 32'(bus.led), 32'h5);
    cyc(2);
    bus.req = 4'b1010;
    cyc(7);
    chk("t4_cnt9_gnt", 32'(bus.gnt), 32'h2);
    chk("t4_cnt9_pre", 32'(bus.preempt), 32'h0);
    cyc(1);
    chk("t4_preempt", 32'(bus.preempt), 32'h1);
    chk("t4_pre_gnt", 32'(bus.gnt), 32'h0);
    bus.req = 4'b1000;
    cyc(1);
    chk("t4_pre_pulse_end", 32'(bus.preempt), 32'h0);
    cyc(1);
    chk("t4_gnt3", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    cyc(6);

    // 5: sole requester holds indefinitely
    bus.req = 4'b0010;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      chk("t5_hold_gnt", 32'(bus.gnt), 32'h2);
      chk("t5_no_preempt", 32'(bus.preempt), 32'h0);
    end
    bus.req = '0;
    cyc(1);
    chk("t5_release", 32'(bus.gnt), 32'h0);
    cyc(2);

    // 6: reset mid-ownership
    bus.req = 4'b0010;
    cyc(2);
    chk("t6_owned", 32'(bus.gnt), 32'h2);
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("t6_rst_led", 32'(bus.led), 32'h0);
    chk("t6_rst_busy", 32'(bus.busy), 32'h0);
    rst     = 1'b0;
    bus.req = 4'b1000;
    cyc(1);
    chk("t6_gnt3", 32'(bus.gnt), 32'h8);
    chk("t6_led3", 32'(bus.led), 32'h9);
    bus.req = '0;
    cyc(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
